// File: rtl/oclib_csr_axil_bridge.sv
// CSR-to-AXI-Lite manager bridge, 32- or 64-bit data, one transaction in flight.
// AW and W retire independently; hung slaves are abandoned after TimeoutCycles.
module oclib_csr_axil_bridge #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [AddressWidth-1:0] csr_address,
  input  logic [DataWidth-1:0]    csr_wdata,
  output logic                    csr_ready,
  output logic                    csr_error,
  output logic [DataWidth-1:0]    csr_rdata,
  output logic [AddressWidth-1:0] axil_awaddr,
  output logic                    axil_awvalid,
  input  logic                    axil_awready,
  output logic [DataWidth-1:0]    axil_wdata,
  output logic [DataWidth/8-1:0]  axil_wstrb,
  output logic                    axil_wvalid,
  input  logic                    axil_wready,
  input  logic [1:0]              axil_bresp,
  input  logic                    axil_bvalid,
  output logic                    axil_bready,
  output logic [AddressWidth-1:0] axil_araddr,
  output logic                    axil_arvalid,
  input  logic                    axil_arready,
  input  logic [DataWidth-1:0]    axil_rdata,
  input  logic [1:0]              axil_rresp,
  input  logic                    axil_rvalid,
  output logic                    axil_rready
);

  if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
    $error("oclib_csr_axil_bridge: DataWidth must be 32 or 64");
  end

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE, DRAIN} state_t;

  state_t                  state, state_d;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;
  logic                    is_read;
  logic                    aw_done;
  logic                    w_done;
  logic [CntW-1:0]         tmo_cnt;
  logic                    busy;
  logic                    tmo_hit;
  logic                    aw_hs;
  logic                    w_hs;

  assign busy    = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
  assign tmo_hit = (TimeoutCycles > 0) && busy && (tmo_cnt == CntW'(TimeoutCycles - 1));
  assign aw_hs   = axil_awvalid && axil_awready;
  assign w_hs    = axil_wvalid && axil_wready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (csr_read && csr_write) state_d = DONE;
        else if (csr_write)        state_d = WADDR;
        else if (csr_read)         state_d = RADDR;
      end
      WADDR: begin
        if (tmo_hit)                                      state_d = DONE;
        else if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WRESP;
      end
      WRESP:   if (tmo_hit || axil_bvalid) state_d = DONE;
      RADDR: begin
        if (tmo_hit)           state_d = DONE;
        else if (axil_arready) state_d = RDATA;
      end
      RDATA:   if (tmo_hit || axil_rvalid) state_d = DONE;
      DONE:    state_d = DRAIN;
      DRAIN:   if (!csr_read && !csr_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A timeout drops valids/readys without a handshake to walk away from a hung slave.
  always_comb begin
    axil_awvalid = (state == WADDR) && !aw_done && !tmo_hit;
    axil_wvalid  = (state == WADDR) && !w_done && !tmo_hit;
    axil_bready  = (state == WRESP) && !tmo_hit;
    axil_arvalid = (state == RADDR) && !tmo_hit;
    axil_rready  = (state == RDATA) && !tmo_hit;
    axil_awaddr  = addr_q;
    axil_araddr  = addr_q;
    axil_wdata   = wdata_q;
    axil_wstrb   = '1;
    csr_ready    = (state == DONE);
    csr_error    = (state == DONE) && err_q;
    csr_rdata    = ((state == DONE) && !is_read) ? '0 : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      is_read <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        tmo_cnt <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (csr_read || csr_write) begin
          addr_q  <= csr_address;
          wdata_q <= csr_wdata;
          err_q   <= csr_read && csr_write;
          is_read <= csr_read && !csr_write;
        end
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + CntW'(1);
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (tmo_hit) begin
        err_q <= 1'b1;
      end else if (axil_bvalid && axil_bready) begin
        err_q <= (axil_bresp != 2'b00);
      end else if (axil_rvalid && axil_rready) begin
        err_q   <= (axil_rresp != 2'b00);
        rdata_q <= axil_rdata;
      end
    end
  end

endmodule

// File: tb/tb_oclib_csr_axil_bridge.sv
// Bench for oclib_csr_axil_bridge: a 32-bit instance (16-cycle timeout) and a 64-bit
// instance (no timeout) share one behavioural AXI-Lite slave selected by 'sel'.
module tb_oclib_csr_axil_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        rd32 = 1'b0, wr32 = 1'b0, rd64 = 1'b0, wr64 = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [63:0] rdata = '0;

  logic        rdy32, err32, awv32, wv32, bready32, arv32, rready32;
  logic [31:0] rdat32, awaddr32, araddr32, wdat32;
  logic [3:0]  wstrb32;
  logic        rdy64, err64, awv64, wv64, bready64, arv64, rready64;
  logic [63:0] rdat64, wdat64;
  logic [31:0] awaddr64, araddr64;
  logic [7:0]  wstrb64;

  oclib_csr_axil_bridge #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(16)) u32 (
    .clock(clock), .reset(reset), .csr_read(rd32), .csr_write(wr32),
    .csr_address(addr), .csr_wdata(wdata[31:0]), .csr_ready(rdy32), .csr_error(err32),
    .csr_rdata(rdat32), .axil_awaddr(awaddr32), .axil_awvalid(awv32), .axil_awready(awready),
    .axil_wdata(wdat32), .axil_wstrb(wstrb32), .axil_wvalid(wv32), .axil_wready(wready),
    .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready32),
    .axil_araddr(araddr32), .axil_arvalid(arv32), .axil_arready(arready),
    .axil_rdata(rdata[31:0]), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready32));

  oclib_csr_axil_bridge #(.DataWidth(64), .AddressWidth(32), .TimeoutCycles(0)) u64 (
    .clock(clock), .reset(reset), .csr_read(rd64), .csr_write(wr64),
    .csr_address(addr), .csr_wdata(wdata), .csr_ready(rdy64), .csr_error(err64),
    .csr_rdata(rdat64), .axil_awaddr(awaddr64), .axil_awvalid(awv64), .axil_awready(awready),
    .axil_wdata(wdat64), .axil_wstrb(wstrb64), .axil_wvalid(wv64), .axil_wready(wready),
    .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready64),
    .axil_araddr(araddr64), .axil_arvalid(arv64), .axil_arready(arready),
    .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready64));

  logic        sel = 1'b0;
  logic        s_awv, s_wv, s_bready, s_arv, s_rready, s_rdy, s_err;
  logic [31:0] s_awaddr, s_araddr;
  logic [63:0] s_wdat, s_rdat;
  logic [7:0]  s_wstrb;
  assign s_awv    = sel ? awv64    : awv32;
  assign s_wv     = sel ? wv64     : wv32;
  assign s_bready = sel ? bready64 : bready32;
  assign s_arv    = sel ? arv64    : arv32;
  assign s_rready = sel ? rready64 : rready32;
  assign s_rdy    = sel ? rdy64    : rdy32;
  assign s_err    = sel ? err64    : err32;
  assign s_awaddr = sel ? awaddr64 : awaddr32;
  assign s_araddr = sel ? araddr64 : araddr32;
  assign s_wdat   = sel ? wdat64   : {32'h0, wdat32};
  assign s_rdat   = sel ? rdat64   : {32'h0, rdat32};
  assign s_wstrb  = sel ? wstrb64  : {4'h0, wstrb32};

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, lat = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [63:0] cfg_rdata = '0;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int aw_beats, w_beats, b_beats, ar_beats, r_beats;
  int aw_stale, w_stale, valid_cycles, bready_after, rdy_pulses, rdy_cyc, aw_hs_cyc, w_hs_cyc;
  bit b_taken, r_taken;
  logic        err_seen;
  logic [63:0] rdat_seen, got_wdata;
  logic [31:0] got_awaddr, got_araddr;
  logic [7:0]  got_wstrb;

  // Slave decides its readies/valids each negedge; a handshake is booked for the
  // following posedge. B/R are evaluated before AW/W/AR so responses trail the requests.
  always @(negedge clock) begin
    cyc++;
    if (s_rdy) begin
      if (rdy_pulses == 0) begin
        rdy_cyc = cyc; err_seen = s_err; rdat_seen = s_rdat;
      end
      rdy_pulses++;
    end else if (rdy_pulses > 0 && s_bready) begin
      bready_after++;
    end
    if (s_awv || s_wv || s_arv) valid_cycles++;
    if (s_awv && aw_beats > 0) aw_stale++;
    if (s_wv && w_beats > 0)   w_stale++;

    if (b_taken) begin
      bvalid = 1'b0; b_taken = 1'b0;
    end else if (!bvalid && b_beats == 0 && aw_beats > 0 && w_beats > 0) begin
      if (b_wait >= b_dly) begin bvalid = 1'b1; bresp = cfg_bresp; end
      else b_wait++;
    end
    if (bvalid && s_bready) begin b_beats++; b_taken = 1'b1; end

    if (r_taken) begin
      rvalid = 1'b0; r_taken = 1'b0;
    end else if (!rvalid && r_beats == 0 && ar_beats > 0) begin
      if (r_wait >= r_dly) begin rvalid = 1'b1; rresp = cfg_rresp; rdata = cfg_rdata; end
      else r_wait++;
    end
    if (rvalid && s_rready) begin r_beats++; r_taken = 1'b1; end

    awready = 1'b0;
    if (s_awv && aw_beats == 0) begin
      if (aw_wait >= aw_dly) begin
        awready = 1'b1; aw_beats++; got_awaddr = s_awaddr; aw_hs_cyc = cyc;
      end else aw_wait++;
    end
    wready = 1'b0;
    if (s_wv && w_beats == 0) begin
      if (w_wait >= w_dly) begin
        wready = 1'b1; w_beats++; got_wdata = s_wdat; got_wstrb = s_wstrb; w_hs_cyc = cyc;
      end else w_wait++;
    end
    arready = 1'b0;
    if (s_arv && ar_beats == 0) begin
      if (ar_wait >= ar_dly) begin arready = 1'b1; ar_beats++; got_araddr = s_araddr; end
      else ar_wait++;
    end
  end

  task automatic slave_clear();
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
    aw_stale = 0; w_stale = 0; valid_cycles = 0; bready_after = 0;
    rdy_pulses = 0; rdy_cyc = 0; aw_hs_cyc = 0; w_hs_cyc = 0;
    b_taken = 1'b0; r_taken = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    err_seen = 1'b0; rdat_seen = '0; got_wdata = '0; got_awaddr = '0; got_araddr = '0; got_wstrb = '0;
  endtask

  // Called at posedge+1; the request's first cycle is cycle 0 and lat is the
  // cycle index of the first csr_ready pulse (-1 if none within the bound).
  task automatic run_txn(input bit s, input bit w, input bit r, input logic [31:0] a,
                         input logic [63:0] d, input int hold);
    slave_clear();
    sel = s; addr = a; wdata = d; t0 = cyc;
    if (s) begin rd64 = r; wr64 = w; end
    else   begin rd32 = r; wr32 = w; end
    for (int i = 0; i < 100 && rdy_pulses == 0; i++) begin @(posedge clock); #1; end
    repeat (hold) begin @(posedge clock); #1; end
    rd32 = 1'b0; wr32 = 1'b0; rd64 = 1'b0; wr64 = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    lat = (rdy_pulses > 0) ? rdy_cyc - t0 - 1 : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if ({rdy32, err32, awv32, wv32, bready32, arv32, rready32} !== 7'b0) begin
      errors++; $display("FAIL reset32_ctrl got %b exp 0", {rdy32, err32, awv32, wv32, bready32, arv32, rready32});
    end
    checks++; if ({rdy64, err64, awv64, wv64, bready64, arv64, rready64} !== 7'b0) begin
      errors++; $display("FAIL reset64_ctrl got %b exp 0", {rdy64, err64, awv64, wv64, bready64, arv64, rready64});
    end
    checks++; if (rdat64 !== 64'h0 || rdat32 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0", rdat64, rdat32);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write32_basic();
    aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = 2'd0;
    run_txn(1'b0, 1'b1, 1'b0, 32'h10, 64'hDEADBEEF, 1);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr32_latency got %0d exp 3", lat); end
    checks++; if (got_awaddr !== 32'h10) begin errors++; $display("FAIL wr32_awaddr got %h exp 10", got_awaddr); end
    checks++; if (got_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL wr32_wdata got %h exp deadbeef", got_wdata); end
    checks++; if (got_wstrb !== 8'h0F) begin errors++; $display("FAIL wr32_wstrb got %h exp 0f", got_wstrb); end
    checks++; if (err_seen !== 1'b0 || rdy_pulses !== 1) begin
      errors++; $display("FAIL wr32_done got err %b pulses %0d exp 0/1", err_seen, rdy_pulses);
    end
  endtask

  task automatic test_read64_slverr();
    ar_dly = 5; r_dly = 0; cfg_rresp = 2'd2; cfg_rdata = 64'h0123456789ABCDEF;
    run_txn(1'b1, 1'b0, 1'b1, 32'h08, 64'h0, 3);
    checks++; if (rdat_seen !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL rd64_rdata got %h exp 0123456789abcdef", rdat_seen);
    end
    checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL rd64_error got %b exp 1", err_seen); end
    checks++; if (rdy_pulses !== 1) begin errors++; $display("FAIL rd64_pulses got %0d exp 1", rdy_pulses); end
    checks++; if (lat !== 8 || got_araddr !== 32'h08) begin
      errors++; $display("FAIL rd64_latency_addr got %0d/%h exp 8/08", lat, got_araddr);
    end
  endtask

  task automatic test_independent_aw_w();
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 4 : 0; w_dly = (k == 0) ? 0 : 4; b_dly = 0; cfg_bresp = 2'd0;
      run_txn(1'b0, 1'b1, 1'b0, 32'h40 + k, 64'h5A5A0000 + k, 0);
      checks++; if (aw_beats !== 1 || w_beats !== 1 || aw_stale !== 0 || w_stale !== 0) begin
        errors++; $display("FAIL indep%0d_beats got aw %0d w %0d stale %0d/%0d exp 1 1 0/0",
                           k, aw_beats, w_beats, aw_stale, w_stale);
      end
      checks++; if (aw_hs_cyc - w_hs_cyc !== ((k == 0) ? 4 : -4)) begin
        errors++; $display("FAIL indep%0d_order got %0d exp %0d", k, aw_hs_cyc - w_hs_cyc, (k == 0) ? 4 : -4);
      end
      checks++; if (lat !== 7 || err_seen !== 1'b0 || rdy_pulses !== 1) begin
        errors++; $display("FAIL indep%0d_done got lat %0d err %b pulses %0d exp 7 0 1", k, lat, err_seen, rdy_pulses);
      end
    end
  endtask

  task automatic test_timeout();
    // bvalid arrives far too late (after the bridge has given up)
    aw_dly = 0; w_dly = 0; b_dly = 30; cfg_bresp = 2'd0;
    run_txn(1'b0, 1'b1, 1'b0, 32'h20, 64'h11111111, 0);
    repeat (20) begin @(posedge clock); #1; end
    // AW/W issue in cycle 1; the abort pulse lands 16 cycles after that
    checks++; if (lat !== 17 || err_seen !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse got lat %0d err %b exp 17 1", lat, err_seen);
    end
    checks++; if (rdy_pulses !== 1 || bready_after !== 0) begin
      errors++; $display("FAIL timeout_late_b got pulses %0d bready %0d exp 1 0", rdy_pulses, bready_after);
    end
  endtask

  task automatic test_illegal();
    run_txn(1'b1, 1'b1, 1'b1, 32'h30, 64'h0, 10);
    checks++; if (lat !== 1 || err_seen !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse got lat %0d err %b exp 1 1", lat, err_seen);
    end
    checks++; if (rdy_pulses !== 1 || valid_cycles !== 0) begin
      errors++; $display("FAIL illegal_quiet got pulses %0d valids %0d exp 1 0", rdy_pulses, valid_cycles);
    end
  endtask

  task automatic test_reset_mid_read();
    slave_clear();
    ar_dly = 0; r_dly = 20; cfg_rresp = 2'd0; cfg_rdata = 64'hCAFE;
    sel = 1'b1; addr = 32'h50; rd64 = 1'b1;
    for (int i = 0; i < 20 && rready64 !== 1'b1; i++) begin @(posedge clock); #1; end
    checks++; if (rready64 !== 1'b1) begin errors++; $display("FAIL rst_reach_rdata got %b exp 1", rready64); end
    reset = 1'b1; rd64 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if ({rdy64, err64, awv64, wv64, bready64, arv64, rready64} !== 7'b0 || rdat64 !== 64'h0) begin
      errors++; $display("FAIL rst_outputs got %b rdata %h exp 0", {rdy64, err64, awv64, wv64, bready64, arv64, rready64}, rdat64);
    end
    repeat (5) begin @(posedge clock); #1; end
    checks++; if (rdy_pulses !== 0) begin errors++; $display("FAIL rst_no_ready got %0d exp 0", rdy_pulses); end
    r_dly = 0; cfg_rdata = 64'hFEEDFACE12345678;
    run_txn(1'b1, 1'b0, 1'b1, 32'h58, 64'h0, 0);
    checks++; if (lat !== 3 || rdat_seen !== 64'hFEEDFACE12345678 || err_seen !== 1'b0) begin
      errors++; $display("FAIL rst_after_read got lat %0d rdata %h err %b exp 3 feedface12345678 0", lat, rdat_seen, err_seen);
    end
  endtask

  // Random traffic against a model: latency = 3 + slave stalls, one beat per channel,
  // error = (resp != OKAY), rdata = slave data masked to width (0 on writes).
  task automatic test_random();
    bit          s, w;
    logic [31:0] a;
    logic [63:0] d, dmask, exp_rdat;
    int          exp_lat;
    logic        exp_err;
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(1, 0)); w = 1'($urandom_range(1, 0));
      a = $urandom & 32'hFFFF_FFFC; d = {$urandom, $urandom};
      aw_dly = $urandom_range(4, 0); w_dly = $urandom_range(4, 0); b_dly = $urandom_range(4, 0);
      ar_dly = $urandom_range(4, 0); r_dly = $urandom_range(4, 0);
      cfg_bresp = 2'($urandom_range(3, 0)); cfg_rresp = 2'($urandom_range(3, 0));
      cfg_rdata = {$urandom, $urandom};
      run_txn(s, w, !w, a, d, $urandom_range(2, 0));
      dmask    = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      exp_lat  = w ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      exp_err  = w ? (cfg_bresp != 2'd0) : (cfg_rresp != 2'd0);
      exp_rdat = w ? 64'h0 : (cfg_rdata & dmask);
      checks++; if (rdy_pulses !== 1 || lat !== exp_lat) begin
        errors++; $display("FAIL rand%0d_timing got pulses %0d lat %0d exp 1 %0d", n, rdy_pulses, lat, exp_lat);
      end
      checks++; if (err_seen !== exp_err || rdat_seen !== exp_rdat) begin
        errors++; $display("FAIL rand%0d_resp got err %b rdata %h exp %b %h", n, err_seen, rdat_seen, exp_err, exp_rdat);
      end
      if (w) begin
        checks++; if (aw_beats !== 1 || w_beats !== 1 || ar_beats !== 0 || got_awaddr !== a ||
                      got_wdata !== (d & dmask) || got_wstrb !== (s ? 8'hFF : 8'h0F)) begin
          errors++; $display("FAIL rand%0d_wr got aw %0d w %0d ar %0d addr %h data %h strb %h exp 1 1 0 %h %h %h",
                             n, aw_beats, w_beats, ar_beats, got_awaddr, got_wdata, got_wstrb,
                             a, d & dmask, s ? 8'hFF : 8'h0F);
        end
      end else begin
        checks++; if (ar_beats !== 1 || aw_beats !== 0 || w_beats !== 0 || got_araddr !== a) begin
          errors++; $display("FAIL rand%0d_rd got ar %0d aw %0d w %0d addr %h exp 1 0 0 %h",
                             n, ar_beats, aw_beats, w_beats, got_araddr, a);
        end
      end
    end
  endtask

  initial begin
    slave_clear();
    test_reset();
    test_write32_basic();
    test_read64_slverr();
    test_independent_aw_w();
    test_timeout();
    test_illegal();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
